sodor_dmem_responder: RTL
=========================

Name: sodor_dmem_responder

Overview:
- Data-memory responder for the Sodor 5-stage core's data port: the memory-side end of the core's load/store request interface.
- Accepts one load or store per cycle from the core's memory stage, performs byte/half/word access on an internal word-addressed RAM, and returns the response after a fixed, parameterised latency.
- Used in the two-copy security benches so that load data (and the core's load-buffer contents) comes from a real sequential memory, not a combinational array.
- Has a side preload port so a bench can initialise memory contents.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; legal byte range is 0 .. DEPTH_WORDS*4-1.
- LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..4.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_fcn  in  1  0 = load, 1 = store (core mem_fcn encoding).
- req_typ  in  3  1=B, 2=H, 3=W, 4=BU, 5=HU (core mem_typ encoding); 0, 6 and 7 are illegal.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response strobe.
- resp_data  out  32  load result, sign- or zero-extended; 0 for stores and errors.
- resp_err  out  1  request was rejected (misaligned, out of range, or illegal typ).
- init_we  in  1  preload write enable.
- init_addr  in  $clog2(DEPTH_WORDS)  preload word index.
- init_data  in  32  preload word.

Behaviour:
- Reset (asynchronous assert, synchronous-edge release):
  - resp_valid=0, resp_data=0, resp_err=0, req_ready=0.
  - All latency-pipeline stages are cleared.
  - RAM contents are not reset.
- req_ready=1 from the first clock edge after reset deasserts, and stays high (no backpressure).
- Acceptance: a request is accepted when req_valid && req_ready at a rising edge.
- Accepted store:
  - The RAM write is applied at that same edge, byte lanes selected by req_addr[1:0].
  - B writes lane addr[1:0] with wdata[7:0].
  - H writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - W writes all four lanes.
  - The store still produces a response with resp_data=0.
- Accepted load:
  - The word is read at the acceptance edge, so it sees every write committed at earlier edges. A store accepted at edge N is visible to a load accepted at edge N+1.
  - The result is extracted by lane: B/H sign-extend; BU/HU zero-extend; W is returned as-is.
- Error check, done at acceptance. Any of the following sets resp_err=1, resp_data=0, and suppresses any RAM write:
  - req_typ illegal.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - addr >= DEPTH_WORDS*4.
- Latency:
  - The response for a request accepted at edge N appears with resp_valid=1 during the cycle after edge N+LATENCY-1. With LATENCY=1 it is visible in the cycle right after acceptance.
  - The pipeline is a LATENCY-deep shift register of {valid, data, err}.
  - Responses return in order, one per accepted request, and back-to-back acceptance gives back-to-back responses.
- resp_data and resp_err hold their last values when resp_valid=0.
- Preload:
  - init_we writes init_data to init_addr at the edge.
  - If an accepted store hits the same word in the same cycle, the store's lanes override the preload on those lanes; the other lanes take init_data.
  - Preload works during reset.
- Reset during operation: in-flight responses are dropped and never emitted. Stores already accepted remain in RAM.

Test Plan:
- Reset, then preload word 1 = 0x8001_7FFE; load W at 0x4 (LATENCY=1) -> resp_valid one cycle later, resp_data=0x80017FFE, resp_err=0.
- Same word: load B at 0x7, BU at 0x7, H at 0x6, HU at 0x6 back-to-back -> responses on consecutive cycles: 0xFFFFFF80, 0x00000080, 0xFFFF8001, 0x00008001.
- Store B 0xAB at 0x5 accepted at edge N, load W at 0x4 accepted at edge N+1 -> store response data 0, then load returns 0x8001ABFE.
- Error cases:
  - load H at 0x3 -> resp_err=1, resp_data=0.
  - store W at DEPTH_WORDS*4 -> resp_err=1, and a following W load at 0x0 is unchanged.
  - req_typ=7 -> resp_err=1.
- LATENCY=3: loads accepted at edges 10, 11, 12 -> resp_valid at cycles following edges 12, 13, 14, in order. Reset asserted between edges 11 and 12 -> no responses emitted, and req_ready=0 until the first edge after release.
- Preload word 0 = 0x11111111 while a store H 0x2222 to 0x2 is accepted the same cycle -> load W at 0x0 returns 0x22221111.

Source files
------------

// File: rtl/sodor_dmem_responder.sv
// Memory-side responder for the Sodor core data port: word-addressed RAM with
// byte/half/word access, a preload side port, and a fixed-latency in-order response pipe.
module sodor_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 1,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  input  logic          req_fcn,
  input  logic [2:0]    req_typ,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_data,
  output logic          resp_err,
  input  logic          init_we,
  input  logic [AW-1:0] init_addr,
  input  logic [31:0]   init_data
);

  localparam int unsigned BYTES = DEPTH_WORDS * 4;

  localparam logic [2:0] TYP_B  = 3'd1;
  localparam logic [2:0] TYP_H  = 3'd2;
  localparam logic [2:0] TYP_W  = 3'd3;
  localparam logic [2:0] TYP_BU = 3'd4;
  localparam logic [2:0] TYP_HU = 3'd5;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic          req_err;
  logic          wr_en;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   rword;
  logic [31:0]   rshift;
  logic [31:0]   ld_data;
  logic [31:0]   stage0_data;

  // Request decode: error check, store lane mask and load extraction
  always_comb begin
    accept    = req_valid && req_ready;
    lane      = req_addr[1:0];
    word_idx  = req_addr[AW+1:2];
    req_err   = 1'b0;
    be        = 4'b0000;
    wdata_rep = req_wdata;
    ld_data   = 32'h0;

    unique case (req_typ)
      TYP_B, TYP_BU: ;
      TYP_H, TYP_HU: req_err = req_addr[0];
      TYP_W:         req_err = (lane != 2'b00);
      default:       req_err = 1'b1;
    endcase
    if (req_addr >= 32'(BYTES)) req_err = 1'b1;

    unique case (req_typ)
      TYP_B, TYP_BU: begin
        be        = 4'(4'b0001 << lane);
        wdata_rep = {4{req_wdata[7:0]}};
      end
      TYP_H, TYP_HU: begin
        be        = 4'(4'b0011 << {lane[1], 1'b0});
        wdata_rep = {2{req_wdata[15:0]}};
      end
      TYP_W:   be = 4'b1111;
      default: be = 4'b0000;
    endcase

    // Out-of-range reads are never used; the error path forces data to zero
    rword  = mem[word_idx];
    rshift = rword >> {lane, 3'b000};
    unique case (req_typ)
      TYP_B:   ld_data = {{24{rshift[7]}}, rshift[7:0]};
      TYP_BU:  ld_data = {24'h0, rshift[7:0]};
      TYP_H:   ld_data = {{16{rshift[15]}}, rshift[15:0]};
      TYP_HU:  ld_data = {16'h0, rshift[15:0]};
      TYP_W:   ld_data = rword;
      default: ld_data = 32'h0;
    endcase

    wr_en       = accept && req_fcn && !req_err;
    stage0_data = (req_err || req_fcn) ? 32'h0 : ld_data;
  end

  // RAM: not reset; store lanes are written after the preload so they win per lane
  always_ff @(posedge clock) begin
    if (init_we) mem[init_addr] <= init_data;
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][i*8 +: 8] <= wdata_rep[i*8 +: 8];
      end
    end
  end

  logic [LATENCY-1:0]       pipe_valid;
  logic [LATENCY-1:0][31:0] pipe_data;
  logic [LATENCY-1:0]       pipe_err;

  // Response shift register; payload only advances with a valid so outputs hold when idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_ready  <= 1'b0;
      pipe_valid <= '0;
      pipe_data  <= '0;
      pipe_err   <= '0;
    end else begin
      req_ready     <= 1'b1;
      pipe_valid[0] <= accept;
      if (accept) begin
        pipe_data[0] <= stage0_data;
        pipe_err[0]  <= req_err;
      end
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
          pipe_err[i]  <= pipe_err[i-1];
        end
      end
    end
  end

  assign resp_valid = pipe_valid[LATENCY-1];
  assign resp_data  = pipe_data[LATENCY-1];
  assign resp_err   = pipe_err[LATENCY-1];

endmodule
